// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: fetch-stage PC generator with exception/eret vectors, stall hold,
// and a one-entry buffer for redirects that arrive while fetch is stalled.
module fetch_pc_unit #(
   parameter int unsigned          WIDTH      = 32,
   parameter logic [WIDTH-1:0]     RESET_PC   = 32'h0000_3000,
   parameter logic [WIDTH-1:0]     EXC_VECTOR = 32'h0000_4180,
   parameter int unsigned          INC        = 4,
   parameter logic [WIDTH-1:0]     IM_BASE    = 32'h0000_3000,
   parameter logic [WIDTH-1:0]     IM_SIZE    = 32'h0000_4000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall_i,
   input  logic             br_valid_i,
   input  logic [WIDTH-1:0] br_target_i,
   input  logic             exc_req_i,
   input  logic             eret_i,
   input  logic [WIDTH-1:0] epc_i,
   output logic [WIDTH-1:0] pc_o,
   output logic [WIDTH-1:0] pc_plus_o,
   output logic             pend_o,
   output logic             adel_o
);
   typedef enum logic {RUN, HOLD} state_t;

   localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);
   // Window end kept one bit wider so a window reaching the top of the space stays legal
   localparam logic [WIDTH:0]   IM_END = {1'b0, IM_BASE} + {1'b0, IM_SIZE};

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_pc, r_tgt, w_pc_nxt, w_tgt_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= RUN;
         r_pc    <= RESET_PC;
         r_tgt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_tgt   <= w_tgt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = pc_plus_o;
      w_tgt_nxt   = r_tgt;
      if (exc_req_i) begin
         w_pc_nxt    = EXC_VECTOR;
         w_state_nxt = RUN;
      end else if (eret_i) begin
         w_pc_nxt    = epc_i;
         w_state_nxt = RUN;
      end else if (stall_i) begin
         w_pc_nxt = r_pc;
         if (br_valid_i) begin
            w_tgt_nxt   = br_target_i;
            w_state_nxt = HOLD;
         end
      end else begin
         w_pc_nxt    = br_valid_i ? br_target_i : (r_state == HOLD) ? r_tgt : pc_plus_o;
         w_state_nxt = RUN;
      end
   end

   assign pc_o      = r_pc;
   assign pc_plus_o = r_pc + INC_W;
   assign pend_o    = (r_state == HOLD);
   assign adel_o    = (|r_pc[1:0]) || (r_pc < IM_BASE) || ({1'b0, r_pc} >= IM_END);
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: directed vectors; expectations queued at each edge and
// checked by an independent monitor on the falling edge.
module tb_fetch_pc_unit;
   logic        clk = 0;
   logic        reset, stall_i, br_valid_i, exc_req_i, eret_i;
   logic [31:0] br_target_i, epc_i, pc_o, pc_plus_o;
   logic        pend_o, adel_o;

   typedef struct {
      int          id;
      logic [31:0] pc;
      logic        pend;
      logic        adel;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   vec    = 0;

   fetch_pc_unit dut (
      .clk(clk), .reset(reset), .stall_i(stall_i), .br_valid_i(br_valid_i),
      .br_target_i(br_target_i), .exc_req_i(exc_req_i), .eret_i(eret_i),
      .epc_i(epc_i), .pc_o(pc_o), .pc_plus_o(pc_plus_o), .pend_o(pend_o),
      .adel_o(adel_o)
   );

   always #5 clk = ~clk;

   task automatic cyc(input logic rst, input logic st, input logic br, input logic [31:0] tgt,
                      input logic exc, input logic er, input logic [31:0] epc,
                      input logic [31:0] e_pc, input logic e_pend, input logic e_adel);
      exp_t e;
      reset = rst; stall_i = st; br_valid_i = br; br_target_i = tgt;
      exc_req_i = exc; eret_i = er; epc_i = epc;
      @(posedge clk);
      #1;
      e.id = vec; e.pc = e_pc; e.pend = e_pend; e.adel = e_adel;
      q.push_back(e);
      vec++;
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         checks += 4;
         if (pc_o !== e.pc) begin
            errors++;
            $display("FAIL pc vec%0d: got %h want %h", e.id, pc_o, e.pc);
         end
         if (pc_plus_o !== e.pc + 32'd4) begin
            errors++;
            $display("FAIL pc_plus vec%0d: got %h want %h", e.id, pc_plus_o, e.pc + 32'd4);
         end
         if (pend_o !== e.pend) begin
            errors++;
            $display("FAIL pend vec%0d: got %b want %b", e.id, pend_o, e.pend);
         end
         if (adel_o !== e.adel) begin
            errors++;
            $display("FAIL adel vec%0d: got %b want %b", e.id, adel_o, e.adel);
         end
      end
   end

   initial begin
      // rst st br tgt  exc er epc  -> pc pend adel
      cyc(1, 0, 0, 32'h0,        0, 0, 32'h0,    32'h0000_3000, 0, 0);
      cyc(0, 0, 0, 32'h0,        0, 0, 32'h0,    32'h0000_3004, 0, 0);
      cyc(0, 0, 0, 32'h0,        0, 0, 32'h0,    32'h0000_3008, 0, 0);
      cyc(0, 0, 0, 32'h0,        0, 0, 32'h0,    32'h0000_300C, 0, 0);
      cyc(0, 0, 0, 32'h0,        0, 0, 32'h0,    32'h0000_3010, 0, 0);
      cyc(0, 0, 1, 32'h3100,     0, 0, 32'h0,    32'h0000_3100, 0, 0);
      cyc(0, 0, 0, 32'h0,        0, 0, 32'h0,    32'h0000_3104, 0, 0);
      cyc(0, 0, 1, 32'h3020,     0, 0, 32'h0,    32'h0000_3020, 0, 0);
      cyc(0, 1, 1, 32'h3200,     0, 0, 32'h0,    32'h0000_3020, 1, 0);
      cyc(0, 1, 0, 32'h0,        0, 0, 32'h0,    32'h0000_3020, 1, 0);
      cyc(0, 1, 0, 32'h0,        0, 0, 32'h0,    32'h0000_3020, 1, 0);
      cyc(0, 0, 0, 32'h0,        0, 0, 32'h0,    32'h0000_3200, 0, 0);
      cyc(0, 1, 1, 32'h3200,     0, 0, 32'h0,    32'h0000_3200, 1, 0);
      cyc(0, 1, 1, 32'h3300,     0, 0, 32'h0,    32'h0000_3200, 1, 0);
      cyc(0, 1, 0, 32'h0,        1, 0, 32'h0,    32'h0000_4180, 0, 0);
      cyc(0, 1, 0, 32'h0,        0, 1, 32'h3024, 32'h0000_3024, 0, 0);
      cyc(0, 0, 0, 32'h0,        1, 1, 32'h3024, 32'h0000_4180, 0, 0);
      cyc(0, 0, 0, 32'h0,        0, 1, 32'h3024, 32'h0000_3024, 0, 0);
      cyc(0, 1, 1, 32'h3400,     0, 0, 32'h0,    32'h0000_3024, 1, 0);
      cyc(0, 1, 1, 32'h3500,     0, 0, 32'h0,    32'h0000_3024, 1, 0);
      cyc(0, 0, 0, 32'h0,        0, 0, 32'h0,    32'h0000_3500, 0, 0);
      cyc(0, 1, 1, 32'h3600,     0, 0, 32'h0,    32'h0000_3500, 1, 0);
      cyc(0, 0, 1, 32'h3700,     0, 0, 32'h0,    32'h0000_3700, 0, 0);
      cyc(0, 0, 0, 32'h0,        0, 0, 32'h0,    32'h0000_3704, 0, 0);
      cyc(0, 0, 1, 32'h3002,     0, 0, 32'h0,    32'h0000_3002, 0, 1);
      cyc(0, 0, 1, 32'h7000,     0, 0, 32'h0,    32'h0000_7000, 0, 1);
      cyc(0, 0, 1, 32'h6FFC,     0, 0, 32'h0,    32'h0000_6FFC, 0, 0);
      cyc(0, 0, 0, 32'h0,        0, 0, 32'h0,    32'h0000_7000, 0, 1);
      cyc(0, 0, 1, 32'h2FFC,     0, 0, 32'h0,    32'h0000_2FFC, 0, 1);
      cyc(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,   32'hFFFF_FFFC, 0, 1);
      cyc(0, 0, 0, 32'h0,        0, 0, 32'h0,    32'h0000_0000, 0, 1);
      cyc(0, 0, 1, 32'h3000,     0, 0, 32'h0,    32'h0000_3000, 0, 0);
      cyc(0, 1, 1, 32'h3800,     0, 0, 32'h0,    32'h0000_3000, 1, 0);
      cyc(1, 1, 0, 32'h0,        0, 0, 32'h0,    32'h0000_3000, 0, 0);
      cyc(0, 0, 0, 32'h0,        0, 0, 32'h0,    32'h0000_3004, 0, 0);
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      if (q.size() > 0) begin
         errors++;
         $display("FAIL drain: got %0d pending want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
